// File: rtl/perf_counter_bank_pkg.sv
// perf_counter_bank_pkg: shared core configuration for the performance counter bank
package perf_counter_bank_pkg;
   localparam int PERF_XLEN    = 32;
   localparam int PERF_CNT_LEN = 64;
   localparam int PERF_N_CNT   = 5;
   localparam int PERF_SEL_W   = 4;

   typedef enum logic [PERF_SEL_W-1:0] {
      CYCLE = 0,
      INSTR = 1,
      FLUSH = 2,
      WAIT  = 3,
      DECOD = 4
   } perf_evt_e;

   function automatic bit perf_hi_port(int xlen, int cnt_len);
      return cnt_len > xlen;
   endfunction

   localparam bit PERF_HI_PORT = perf_hi_port(PERF_XLEN, PERF_CNT_LEN);
endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one counter with increment, half-width write and sticky overflow
module perf_counter_cell
   import perf_counter_bank_pkg::*;
#(
   parameter int XLEN    = PERF_XLEN,
   parameter int CNT_LEN = PERF_CNT_LEN,
   parameter int CNT_INC = 1,
   parameter bit HI_PORT = perf_hi_port(XLEN, CNT_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               wr_en,
   input  logic               wr_hi,
   input  logic [XLEN-1:0]    wr_data,
   input  logic               ovf_clr,
   output logic [CNT_LEN-1:0] cnt_q,
   output logic               ovf_q
);
   logic [CNT_LEN:0]   sum;
   logic [CNT_LEN-1:0] wr_val;
   logic [CNT_LEN-1:0] cnt_d;
   logic               ovf_d;

   assign sum = {1'b0, cnt_q} + (CNT_LEN+1)'(CNT_INC);

   generate
      if (HI_PORT) begin : g_split
         assign wr_val = wr_hi ? {wr_data, cnt_q[XLEN-1:0]} : {cnt_q[CNT_LEN-1:XLEN], wr_data};
      end else begin : g_full
         assign wr_val = wr_data;
      end
   endgenerate

   // Write beats increment; only a real increment carry flags overflow, and it outranks a clear
   always_comb begin
      cnt_d = wr_en ? wr_val : (inc ? sum[CNT_LEN-1:0] : cnt_q);
      ovf_d = (inc & ~wr_en & sum[CNT_LEN]) | (ovf_q & ~ovf_clr);
   end

   // Counter and overflow state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N_CNT event counters with CSR access, inhibit, overflow irq and tear-free split reads
module perf_counter_bank
   import perf_counter_bank_pkg::*;
#(
   parameter int               XLEN         = PERF_XLEN,
   parameter int               CNT_LEN      = PERF_CNT_LEN,
   parameter int               N_CNT        = PERF_N_CNT,
   parameter int               CNT_INC      = 1,
   parameter int               SEL_W        = PERF_SEL_W,
   parameter bit               HI_PORT      = perf_hi_port(XLEN, CNT_LEN),
   parameter logic [N_CNT-1:0] OVF_IRQ_MASK = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CNT-1:0] evt_i,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic             wr_hi,
   input  logic [XLEN-1:0]  wr_data,
   input  logic             rd_en,
   input  logic [SEL_W-1:0] rd_sel,
   input  logic             rd_hi,
   output logic [XLEN-1:0]  rd_data,
   input  logic             inh_wr_en,
   input  logic [N_CNT-1:0] inh_data,
   output logic [N_CNT-1:0] inh_q,
   input  logic [N_CNT-1:0] ovf_clr,
   output logic [N_CNT-1:0] ovf_q,
   output logic             irq_o
);
   localparam int           N_SLOT = 2**SEL_W;
   localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_CNT);

   // Unpopulated select slots read as zero, so an out-of-range rd_sel needs no extra check
   logic [CNT_LEN-1:0] cnt [N_SLOT];
   logic [XLEN-1:0]    live_lo, live_hi;
   logic [XLEN-1:0]    rd_data_d, shadow_q, shadow_d;
   logic [SEL_W-1:0]   shadow_sel_q, shadow_sel_d;
   logic               shadow_vld_q, shadow_vld_d, shadow_hit;
   logic [N_CNT-1:0]   inh_d;
   logic               irq_d;

   generate
      for (genvar i = 0; i < N_SLOT; i++) begin : g_cnt
         if (i < N_CNT) begin : g_cell
            perf_counter_cell #(
               .XLEN    (XLEN),
               .CNT_LEN (CNT_LEN),
               .CNT_INC (CNT_INC),
               .HI_PORT (HI_PORT)
            ) u_cell (
               .clk     (clk),
               .rst     (rst),
               .inc     (evt_i[i] & ~inh_q[i]),
               .wr_en   (wr_en && wr_sel == SEL_W'(i)),
               .wr_hi   (wr_hi),
               .wr_data (wr_data),
               .ovf_clr (ovf_clr[i]),
               .cnt_q   (cnt[i]),
               .ovf_q   (ovf_q[i])
            );
         end else begin : g_nil
            assign cnt[i] = '0;
         end
      end
      if (HI_PORT) begin : g_hi
         assign live_hi = cnt[rd_sel][CNT_LEN-1:XLEN];
      end else begin : g_no_hi
         assign live_hi = '0;
      end
   endgenerate

   assign live_lo    = cnt[rd_sel][XLEN-1:0];
   assign shadow_hit = shadow_vld_q && shadow_sel_q == rd_sel;

   // Low reads snapshot the high half so the following high read sees the same counter value
   always_comb begin
      rd_data_d    = rd_data;
      shadow_d     = shadow_q;
      shadow_sel_d = shadow_sel_q;
      shadow_vld_d = shadow_vld_q;
      if (rd_en && HI_PORT && rd_hi) begin
         rd_data_d    = shadow_hit ? shadow_q : live_hi;
         shadow_vld_d = shadow_vld_q && !shadow_hit;
      end else if (rd_en) begin
         rd_data_d    = live_lo;
         shadow_d     = live_hi;
         shadow_sel_d = rd_sel;
         shadow_vld_d = HI_PORT;
      end
      if (wr_en && {1'b0, wr_sel} < N_LIM && wr_sel == shadow_sel_d) shadow_vld_d = 1'b0;
   end

   // Inhibit mask load and interrupt, which lags the overflow flags by one cycle
   always_comb begin
      inh_d = inh_wr_en ? inh_data : inh_q;
      irq_d = |(ovf_q & OVF_IRQ_MASK);
   end

   // Read port, shadow, inhibit and interrupt state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data      <= '0;
         shadow_q     <= '0;
         shadow_sel_q <= '0;
         shadow_vld_q <= 1'b0;
         inh_q        <= '0;
         irq_o        <= 1'b0;
      end else begin
         rd_data      <= rd_data_d;
         shadow_q     <= shadow_d;
         shadow_sel_q <= shadow_sel_d;
         shadow_vld_q <= shadow_vld_d;
         inh_q        <= inh_d;
         irq_o        <= irq_d;
      end
   end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: vector table, corner sequences and random traffic against a counter bank model
module tb_perf_counter_bank;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  evt_i;
   logic        wr_en, wr_hi, rd_en, rd_hi, inh_wr_en, irq_o;
   logic [3:0]  wr_sel, rd_sel;
   logic [31:0] wr_data, rd_data;
   logic [4:0]  inh_data, inh_q, ovf_clr, ovf_q;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]  evt;
      bit          wen;
      logic [3:0]  wsel;
      bit          whi;
      logic [31:0] wdata;
      bit          ren;
      logic [3:0]  rsel;
      bit          rhi;
      bit          ien;
      logic [4:0]  idata;
      logic [4:0]  clr;
      bit          chk;
      logic [31:0] erd;
      logic [4:0]  eovf;
      bit          eirq;
   } row_t;

   row_t tbl[$];

   longint unsigned m_cnt[5];
   logic [4:0]      m_ovf, m_inh;
   logic            m_irq;
   logic [31:0]     m_rd, m_sh;
   int              m_sh_sel;
   bit              m_sh_vld;

   perf_counter_bank dut (
      .clk(clk), .rst(rst), .evt_i(evt_i),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_hi(wr_hi), .wr_data(wr_data),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_hi(rd_hi), .rd_data(rd_data),
      .inh_wr_en(inh_wr_en), .inh_data(inh_data), .inh_q(inh_q),
      .ovf_clr(ovf_clr), .ovf_q(ovf_q), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   function automatic row_t v(logic [4:0] evt, bit wen, logic [3:0] wsel, bit whi, logic [31:0] wdata,
                              bit ren, logic [3:0] rsel, bit rhi, bit ien, logic [4:0] idata, logic [4:0] clr);
      row_t r;
      r.evt = evt; r.wen = wen; r.wsel = wsel; r.whi = whi; r.wdata = wdata;
      r.ren = ren; r.rsel = rsel; r.rhi = rhi; r.ien = ien; r.idata = idata; r.clr = clr;
      r.chk = 1'b0; r.erd = '0; r.eovf = '0; r.eirq = 1'b0;
      return r;
   endfunction

   function automatic row_t e(row_t r, logic [31:0] erd, logic [4:0] eovf, bit eirq);
      row_t o = r;
      o.chk = 1'b1; o.erd = erd; o.eovf = eovf; o.eirq = eirq;
      return o;
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", n, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = '0; m_inh = '0; m_irq = 1'b0; m_rd = '0; m_sh = '0; m_sh_sel = 0; m_sh_vld = 1'b0;
   endtask

   // One clock of the bank seen as 64-bit counters; all decisions use the state before the edge
   task automatic model_step();
      longint unsigned old[5];
      longint unsigned val;
      logic [4:0] set = '0;
      old = m_cnt;
      if (rd_en) begin
         val = (rd_sel < 5) ? old[rd_sel] : 64'd0;
         if (rd_hi) begin
            if (m_sh_vld && m_sh_sel == int'(rd_sel)) begin
               m_rd = m_sh;
               m_sh_vld = 1'b0;
            end else m_rd = val[63:32];
         end else begin
            m_rd = val[31:0];
            m_sh = val[63:32];
            m_sh_sel = int'(rd_sel);
            m_sh_vld = 1'b1;
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (wr_en && int'(wr_sel) == i) m_cnt[i] = wr_hi ? {wr_data, old[i][31:0]} : {old[i][63:32], wr_data};
         else if (evt_i[i] && !m_inh[i]) begin
            m_cnt[i] = old[i] + 1;
            if (m_cnt[i] == 0) set[i] = 1'b1;
         end
      end
      if (wr_en && wr_sel < 5 && int'(wr_sel) == m_sh_sel) m_sh_vld = 1'b0;
      m_irq = |m_ovf;
      m_ovf = (m_ovf & ~ovf_clr) | set;
      if (inh_wr_en) m_inh = inh_data;
   endtask

   task automatic cyc(input row_t r);
      evt_i = r.evt; wr_en = r.wen; wr_sel = r.wsel; wr_hi = r.whi; wr_data = r.wdata;
      rd_en = r.ren; rd_sel = r.rsel; rd_hi = r.rhi; inh_wr_en = r.ien; inh_data = r.idata; ovf_clr = r.clr;
      model_step();
      @(posedge clk);
      #1;
      chk("model_rd_data", rd_data, m_rd);
      chk("model_ovf_q", ovf_q, m_ovf);
      chk("model_irq_o", irq_o, m_irq);
      chk("model_inh_q", inh_q, m_inh);
   endtask

   initial begin
      row_t r;
      rst = 1'b1;
      r = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      evt_i = '0; wr_en = 0; wr_sel = '0; wr_hi = 0; wr_data = '0;
      rd_en = 0; rd_sel = '0; rd_hi = 0; inh_wr_en = 0; inh_data = '0; ovf_clr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rd_data", rd_data, 0);
      chk("reset_ovf_q", ovf_q, 0);
      chk("reset_irq_o", irq_o, 0);
      chk("reset_inh_q", inh_q, 0);
      rst = 1'b0;

      // count on channel 0, then read it
      for (int k = 0; k < 10; k++) tbl.push_back(v(5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 10, 0, 0));
      // counter 1 all ones, one event wraps it and raises overflow then irq
      tbl.push_back(v(0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(5'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 10, 5'b00010, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 0, 5'b00010, 1));
      // clear colliding with a new overflow keeps the flag; a lone clear drops it
      tbl.push_back(v(0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(5'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010), 0, 5'b00010, 1));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010), 0, 0, 1));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0));
      // tear-free split read of counter 2 while it keeps counting
      tbl.push_back(v(5'b00100, 1, 2, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(5'b00100, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 32'hFFFF_FFFF, 0, 0));
      tbl.push_back(e(v(5'b00100, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0), 0, 0, 0));
      tbl.push_back(e(v(5'b00100, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0), 1, 0, 0));
      // inhibit counter 2 and release it
      tbl.push_back(v(5'b00100, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00100, 0));
      tbl.push_back(v(5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(5'b00100, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 3, 0, 0));
      tbl.push_back(v(5'b00100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(e(v(5'b00100, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 3, 0, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 4, 0, 0));
      // write beats increment
      tbl.push_back(v(5'b01000, 1, 3, 0, 32'h100, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), 32'h100, 0, 0));
      // out-of-range select, read-during-write
      tbl.push_back(v(0, 1, 15, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 15, 0, 0, 0, 0), 0, 0, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 10, 0, 0));
      tbl.push_back(e(v(0, 1, 0, 0, 32'h55, 1, 0, 0, 0, 0, 0), 10, 0, 0));
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 32'h55, 0, 0));
      // low read of counter 2 arms the shadow with high half 1
      tbl.push_back(e(v(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), 4, 0, 0));

      for (int k = 0; k < tbl.size(); k++) begin
         cyc(tbl[k]);
         if (tbl[k].chk) begin
            chk($sformatf("tbl%0d_rd_data", k), rd_data, tbl[k].erd);
            chk($sformatf("tbl%0d_ovf_q", k), ovf_q, tbl[k].eovf);
            chk($sformatf("tbl%0d_irq_o", k), irq_o, tbl[k].eirq);
         end
      end

      // asynchronous reset in the middle of a split read
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rd_data", rd_data, 0);
      chk("async_rst_inh_q", inh_q, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      cyc(v(0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
      chk("post_rst_hi_read", rd_data, 0);

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         r.evt   = 5'($urandom);
         r.wen   = ($urandom_range(0, 3) == 0);
         r.wsel  = 4'($urandom_range(0, 7));
         r.whi   = 1'($urandom);
         r.wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
         r.ren   = 1'($urandom);
         r.rsel  = 4'($urandom_range(0, 7));
         r.rhi   = 1'($urandom);
         r.ien   = ($urandom_range(0, 15) == 0);
         r.idata = 5'($urandom);
         r.clr   = 5'($urandom) & 5'($urandom);
         cyc(r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of N_CNT hardware performance counters. Replaces the fixed cycle/instr/flush/wait/decod counter pairs.
- Sits beside the CSR file: per-cycle event strobes come from the pipeline; the CSR unit reads and writes counters through one XLEN-wide port.
- Adds per-channel inhibit, sticky overflow flags with an interrupt, and tear-free split reads when CNT_LEN > XLEN.

Parameters:
- XLEN, 32, CSR data width.
- CNT_LEN, 64, counter width; must be XLEN or 2*XLEN.
- N_CNT, 5, number of counters (1..16).
- CNT_INC, 1, amount added per event.
- SEL_W, 4, counter select width; must satisfy 2**SEL_W >= N_CNT.
- HI_PORT, (CNT_LEN > XLEN), 1 when counters are split into low/high halves.
- OVF_IRQ_MASK, all ones [N_CNT], channels allowed to raise irq_o.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- evt_i  in  N_CNT  per-channel event strobe, one increment per cycle when high.
- wr_en  in  1  counter write strobe.
- wr_sel  in  SEL_W  counter index for the write.
- wr_hi  in  1  write the high half (ignored when HI_PORT=0).
- wr_data  in  XLEN  write data.
- rd_en  in  1  read strobe.
- rd_sel  in  SEL_W  counter index for the read.
- rd_hi  in  1  read the high half (ignored when HI_PORT=0).
- rd_data  out  XLEN  registered read data.
- inh_wr_en  in  1  inhibit register write strobe.
- inh_data  in  N_CNT  new inhibit mask.
- inh_q  out  N_CNT  current inhibit mask.
- ovf_clr  in  N_CNT  per-channel overflow flag clear.
- ovf_q  out  N_CNT  sticky overflow flags.
- irq_o  out  1  registered overflow interrupt.

Behaviour:
- Reset: all counters, inh_q, ovf_q, rd_data, irq_o and the shadow register are 0. Reset is asynchronous and takes effect immediately, including mid-write or mid-split-read.
- Increment: each cycle, cnt[i] <= cnt[i] + CNT_INC when evt_i[i] & ~inh_q[i]. The addition is mod 2**CNT_LEN.
- Overflow: a carry out of bit CNT_LEN-1 during an increment sets ovf_q[i] on the next edge. The counter wraps to the truncated sum.
- ovf_clr[i] clears ovf_q[i]. If a clear and a new overflow occur in the same cycle, set wins.
- Write, HI_PORT=1: the selected half of cnt[wr_sel] takes wr_data and the other half is preserved.
- Write, HI_PORT=0: the whole counter takes wr_data.
- Write takes priority over increment in the same cycle: the written value is stored, no increment happens, and no overflow is flagged from that cycle.
- wr_sel >= N_CNT: the write is ignored.
- Inhibit: inh_wr_en loads inh_q <= inh_data and takes effect on the following cycle. Events in the load cycle use the old mask.
- Read latency is 1 cycle: rd_data updates on the edge after rd_en and holds its value otherwise.
- Read, low half or HI_PORT=0: returns the live counter value as it stood before that edge's increment.
- Read, HI_PORT=1 and rd_hi=0: also captures the high half of the same counter into a shadow register, with a shadow_sel tag and a valid bit.
- Read, rd_hi=1: if the shadow is valid and shadow_sel == rd_sel, returns the shadow and clears valid. Otherwise returns the live high half.
- Any write to the counter tagged in shadow_sel invalidates the shadow.
- rd_sel >= N_CNT returns 0.
- Read and write to the same counter in the same cycle: the read returns the pre-write value.
- irq_o is registered: irq_o <= |(ovf_q & OVF_IRQ_MASK), so it lags ovf_q by one cycle.

Decomposition:
- Shared core config package receives:
  - PERF_N_CNT and PERF_SEL_W constants.
  - A perf_evt_e enum giving channel indices (CYCLE=0, INSTR=1, FLUSH=2, WAIT=3, DECOD=4).
  - Derivation of HI_PORT from XLEN and PERF_CNT_LEN.
- One sub-module: perf_counter_cell, a single counter with increment, split write, and carry-out/overflow. Instantiated N_CNT times via generate.
- Select decode, the shadow register and the interrupt logic stay at top level.

Test Plan:
- Reset, then evt_i=5'b00001 for 10 cycles -> cnt0=10, all other counters 0; read sel0 low -> rd_data=10 one cycle after rd_en.
- Write cnt1 low=0xFFFFFFFF and high=0xFFFFFFFF, then evt_i[1] for one cycle -> cnt1=0; ovf_q[1]=1 next cycle; irq_o=1 one cycle after that.
- Pulse ovf_clr[1] in the same cycle as a second overflow -> ovf_q[1] stays 1.
- cnt2=0x0000_0000_FFFF_FFFF with evt_i[2] continuously high: read low (gets 0xFFFFFFFF, shadow captures high=0), then read high next cycle -> rd_data=0 from the shadow, not the live value 1.
- inh_data=5'b00100 while evt_i[2] high -> cnt2 increments during the inh_wr_en cycle, then freezes; after clearing the mask, counting resumes one cycle after that write.
- wr_en to cnt3 with wr_data=0x100 while evt_i[3] high -> cnt3=0x100 (no +1).
- wr_sel=15 with N_CNT=5 -> no counter changes; rd_sel=15 -> rd_data=0.
- Assert rst mid-split-read -> rd_data=0, shadow invalid; a following rd_hi returns the live high half.
